uart_adder_ctrl: RTL and testbench
==================================

// Module: uart_adder_ctrl
// PURPOSE
//  Sequencer between the UART byte stream and the 16-bit carry-look-ahead adder.
//  Collects four RX bytes into operands A and B, presents them to the adder, and
//  registers sum and carry. Returns the result as three TX bytes under a valid/ready
//  handshake.
//  Drops partial frames after an inter-byte timeout so the byte stream can resynchronise.
// PARAMETERS
//  TIMEOUT_CYCLES  1000000  idle cycles allowed between bytes of one frame (>=2)
//  CNT_W           20       timeout counter width; must hold TIMEOUT_CYCLES-1
// PORTS
//  clk_i        in   1   clock, all logic rising-edge
//  rst_i        in   1   synchronous reset, active-high
//  rx_valid_i   in   1   one-cycle strobe: rx_data_i holds a received byte
//  rx_data_i    in   8   received byte
//  tx_ready_i   in   1   UART TX can accept a byte this cycle
//  tx_valid_o   out  1   tx_data_o holds a result byte
//  tx_data_o    out  8   result byte
//  add_a_o      out  16  operand A to adder a_i
//  add_b_o      out  16  operand B to adder b_i
//  add_cin_o    out  1   adder cin_i; constant 0
//  add_s_i      in   16  adder sum s_o
//  add_cout_i   in   1   adder carry cout_o
//  busy_o       out  1   1 in CALC or TX
//  overrun_o    out  1   one-cycle pulse: RX byte dropped (arrived in CALC/TX)
//  timeout_o    out  1   one-cycle pulse: partial frame discarded
// BEHAVIOUR
//  Reset: state=RX, byte_idx=0, tmo_cnt=0, add_a_o=add_b_o=0, result regs=0.
//   Reset also forces tx_valid_o=0, tx_data_o=0, busy_o=0, overrun_o=0, timeout_o=0.
//   Reset takes priority over every other event in any state, including mid-frame
//   and mid-TX. No partial output follows reset.
//  Frame order is little-endian: A[7:0], A[15:8], B[7:0], B[15:8].
//  RX: each rx_valid_i writes the byte at byte_idx, then byte_idx++ and tmo_cnt=0.
//   The byte with byte_idx==3 moves the FSM to CALC and sets byte_idx=0.
//  Operand regs drive add_a_o/add_b_o continuously. Adder is combinational; no wait states.
//  CALC: one cycle. Registers sum=add_s_i and cout=add_cout_i. Moves to TX with tx_idx=0.
//   tx_valid_o=1 on the first cycle after the CALC edge.
//   Latency: 4th byte sampled at edge E, tx_valid_o high from edge E+2.
//  TX: sends three bytes: sum[7:0], sum[15:8], {7'b0,cout}.
//   A byte transfers on a cycle with tx_valid_o & tx_ready_i.
//   tx_data_o and tx_valid_o are held stable while tx_ready_i=0. No timeout in TX.
//   The transfer of byte 2 returns the FSM to RX; tx_valid_o=0 on the next cycle.
//   Same-cycle re-accept of RX is not required.
//  Overflow: the 17-bit result is {cout,sum}. cin is always 0, so no signed handling.
//  Timeout: applies in RX with byte_idx!=0 and no rx_valid_i.
//   tmo_cnt++ each cycle; on reaching TIMEOUT_CYCLES-1: byte_idx=0, tmo_cnt=0,
//   pulse timeout_o.
//   Operand regs keep their stale values. With byte_idx==0, tmo_cnt holds at 0.
//   If rx_valid_i arrives on the expiry cycle, the byte is accepted and the timeout
//   is suppressed.
//  rx_valid_i in CALC or TX: byte discarded, overrun_o pulses. No state change.
//  busy_o is registered from the state: 1 exactly while the state is CALC or TX.
// TESTING
//  1 A=0x1234,B=0x4321: RX 34,12,21,43 -> TX 55,55,00; tx_valid_o at E+2.
//  2 A=0xFFFF,B=0x0001 -> TX 00,00,01.
//   A=0xFFFF,B=0xFFFF -> TX FE,FF,01.
//  3 tx_ready_i low 10 cycles on byte 1: tx_data_o=0x55 held, tx_valid_o stays 1.
//   No byte is lost or duplicated.
//  4 TIMEOUT_CYCLES=16: send 2 bytes, idle 16 cycles -> timeout_o pulse, idx=0.
//   Then a full frame 01,00,02,00 -> TX 03,00,00.
//  5 rx_valid_i during TX -> overrun_o one-cycle pulse; TX bytes unchanged.
//  6 rst_i during TX byte 1 -> next cycle all outputs 0, state RX.
//   A new frame then adds correctly.

Source files
------------

// File: rtl/uart_adder_ctrl.sv
// uart_adder_ctrl
// Sequencer between the UART byte stream and an external 16-bit adder.
// Four RX bytes (little-endian A then B) are collected into operand registers
// that drive the adder continuously. One CALC cycle registers sum and carry.
// The result then goes out as three TX bytes under valid/ready:
// sum[7:0], sum[15:8], {7'b0, cout}.
// A partial frame is dropped after TIMEOUT_CYCLES idle cycles.
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       synchronous reset, active high
//   rx_valid_i  one-cycle strobe, rx_data_i holds a received byte
//   rx_data_i   received byte
//   tx_ready_i  UART TX accepts a byte this cycle
//   tx_valid_o  tx_data_o holds a result byte
//   tx_data_o   result byte
//   add_a_o     operand A to adder
//   add_b_o     operand B to adder
//   add_cin_o   adder carry-in, tied to 0
//   add_s_i     adder sum
//   add_cout_i  adder carry-out
//   busy_o      high while in CALC or TX
//   overrun_o   one-cycle pulse, RX byte dropped while in CALC/TX
//   timeout_o   one-cycle pulse, partial frame discarded
//
// State | meaning
// ------+----------------------------------------------------
// RX    | collecting frame bytes, inter-byte timeout active
// CALC  | one cycle, capture adder sum and carry
// TX    | presenting the three result bytes

module uart_adder_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        tx_ready_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    output logic [15:0] add_a_o,
    output logic [15:0] add_b_o,
    output logic        add_cin_o,
    input  logic [15:0] add_s_i,
    input  logic        add_cout_i,
    output logic        busy_o,
    output logic        overrun_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_RX   = 2'd0,
        ST_CALC = 2'd1,
        ST_TX   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_byte_idx;
    logic [1:0]       r_tx_idx;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic [15:0]      r_a;
    logic [15:0]      r_b;
    logic [15:0]      r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_overrun;
    logic             r_timeout;
    logic             w_tx_fire;
    logic             w_in_tx;

    assign w_in_tx   = (r_state == ST_TX);
    assign w_tx_fire = w_in_tx && tx_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RX;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RX: begin
                if (rx_valid_i && (r_byte_idx == 2'd3)) begin
                    w_next_state = ST_CALC;
                end
            end
            ST_CALC: begin
                w_next_state = ST_TX;
            end
            ST_TX: begin
                if (w_tx_fire && (r_tx_idx == 2'd2)) begin
                    w_next_state = ST_RX;
                end
            end
            default: begin
                w_next_state = ST_RX;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_byte_idx <= 2'd0;
            r_tx_idx   <= 2'd0;
            r_tmo_cnt  <= '0;
            r_a        <= 16'd0;
            r_b        <= 16'd0;
            r_sum      <= 16'd0;
            r_cout     <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= (w_next_state == ST_CALC) || (w_next_state == ST_TX);
            case (r_state)
                ST_RX: begin
                    if (rx_valid_i) begin
                        case (r_byte_idx)
                            2'd0:    r_a[7:0]  <= rx_data_i;
                            2'd1:    r_a[15:8] <= rx_data_i;
                            2'd2:    r_b[7:0]  <= rx_data_i;
                            default: r_b[15:8] <= rx_data_i;
                        endcase
                        // 2-bit index wraps 3 -> 0 as the frame completes
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_tmo_cnt  <= '0;
                    end else if (r_byte_idx != 2'd0) begin
                        // Operand registers intentionally keep stale bytes on expiry
                        if (r_tmo_cnt == TMO_LAST) begin
                            r_byte_idx <= 2'd0;
                            r_tmo_cnt  <= '0;
                            r_timeout  <= 1'b1;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end else begin
                        r_tmo_cnt <= '0;
                    end
                end
                ST_CALC: begin
                    r_sum     <= add_s_i;
                    r_cout    <= add_cout_i;
                    r_tx_idx  <= 2'd0;
                    r_overrun <= rx_valid_i;
                end
                ST_TX: begin
                    if (w_tx_fire) begin
                        r_tx_idx <= (r_tx_idx == 2'd2) ? 2'd0 : r_tx_idx + 2'd1;
                    end
                    r_overrun <= rx_valid_i;
                end
                default: begin
                    r_byte_idx <= 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        tx_data_o = 8'd0;
        if (w_in_tx) begin
            case (r_tx_idx)
                2'd0:    tx_data_o = r_sum[7:0];
                2'd1:    tx_data_o = r_sum[15:8];
                default: tx_data_o = {7'd0, r_cout};
            endcase
        end
    end

    assign tx_valid_o = w_in_tx;
    assign add_a_o    = r_a;
    assign add_b_o    = r_b;
    assign add_cin_o  = 1'b0;
    assign busy_o     = r_busy;
    assign overrun_o  = r_overrun;
    assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_uart_adder_ctrl.sv
module tb_uart_adder_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'd0;
    logic        tx_ready_i = 1'b0;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic [15:0] add_a_o;
    logic [15:0] add_b_o;
    logic        add_cin_o;
    logic [15:0] add_s_i;
    logic        add_cout_i;
    logic        busy_o;
    logic        overrun_o;
    logic        timeout_o;

    int n_checks = 0;
    int n_fails  = 0;

    uart_adder_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .tx_ready_i(tx_ready_i), .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
        .add_a_o(add_a_o), .add_b_o(add_b_o), .add_cin_o(add_cin_o),
        .add_s_i(add_s_i), .add_cout_i(add_cout_i),
        .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
    );

    // Combinational adder standing in for the CLA
    assign {add_cout_i, add_s_i} = {1'b0, add_a_o} + {1'b0, add_b_o} + {16'd0, add_cin_o};

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
    endtask

    task automatic recv_byte(input logic [7:0] exp, input string name);
        int n;
        n = 0;
        tx_ready_i = 1'b1;
        while (!tx_valid_o && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (!tx_valid_o) begin
            n_fails++;
            $display("FAIL %s: tx_valid_o never rose within 50 cycles", name);
        end else begin
            n_checks++;
            if (tx_data_o !== exp) begin
                n_fails++;
                $display("FAIL %s: tx_data_o=%02h expected %02h", name, tx_data_o, exp);
            end
            tick();
        end
        tx_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        n_checks++;
        if ({tx_valid_o, tx_data_o, busy_o, overrun_o, timeout_o, add_cin_o} !== 13'd0) begin
            n_fails++;
            $display("FAIL reset_outs: valid=%b data=%02h busy=%b ovr=%b tmo=%b cin=%b expected all 0",
                     tx_valid_o, tx_data_o, busy_o, overrun_o, timeout_o, add_cin_o);
        end
        n_checks++;
        if (add_a_o !== 16'd0 || add_b_o !== 16'd0) begin
            n_fails++;
            $display("FAIL reset_ops: a=%04h b=%04h expected 0000 0000", add_a_o, add_b_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        send_frame(16'h1234, 16'h4321);
        // edge E just sampled the 4th byte: in CALC, not yet valid
        n_checks++;
        if (tx_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fails++;
            $display("FAIL lat_E: valid=%b busy=%b expected 0 1", tx_valid_o, busy_o);
        end
        n_checks++;
        if (add_a_o !== 16'h1234 || add_b_o !== 16'h4321) begin
            n_fails++;
            $display("FAIL operands: a=%04h b=%04h expected 1234 4321", add_a_o, add_b_o);
        end
        tick();
        n_checks++;
        if (tx_valid_o !== 1'b1) begin
            n_fails++;
            $display("FAIL lat_E2: tx_valid_o=%b expected 1", tx_valid_o);
        end
        recv_byte(8'h55, "basic_b0");
        recv_byte(8'h55, "basic_b1");
        recv_byte(8'h00, "basic_b2");
        n_checks++;
        if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fails++;
            $display("FAIL basic_end: valid=%b busy=%b expected 0 0", tx_valid_o, busy_o);
        end
    endtask

    task automatic test_overflow();
        send_frame(16'hFFFF, 16'h0001);
        recv_byte(8'h00, "ovf1_b0");
        recv_byte(8'h00, "ovf1_b1");
        recv_byte(8'h01, "ovf1_b2");
        send_frame(16'hFFFF, 16'hFFFF);
        recv_byte(8'hFE, "ovf2_b0");
        recv_byte(8'hFF, "ovf2_b1");
        recv_byte(8'h01, "ovf2_b2");
    endtask

    task automatic test_backpressure();
        send_frame(16'h1234, 16'h4321);
        tick();
        recv_byte(8'h55, "bp_b0");
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h55) begin
                n_fails++;
                $display("FAIL bp_hold%0d: valid=%b data=%02h expected 1 55", i, tx_valid_o, tx_data_o);
            end
        end
        recv_byte(8'h55, "bp_b1");
        recv_byte(8'h00, "bp_b2");
    endtask

    task automatic test_timeout();
        send_byte(8'h34);
        send_byte(8'h12);
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if (timeout_o !== 1'b0) begin
            n_fails++;
            $display("FAIL tmo_early: timeout_o=%b expected 0", timeout_o);
        end
        tick();
        n_checks++;
        if (timeout_o !== 1'b1) begin
            n_fails++;
            $display("FAIL tmo_pulse: timeout_o=%b expected 1", timeout_o);
        end
        n_checks++;
        if (add_a_o !== 16'h1234) begin
            n_fails++;
            $display("FAIL tmo_stale: add_a_o=%04h expected 1234", add_a_o);
        end
        tick();
        n_checks++;
        if (timeout_o !== 1'b0) begin
            n_fails++;
            $display("FAIL tmo_width: timeout_o=%b expected 0", timeout_o);
        end
        send_frame(16'h0001, 16'h0002);
        recv_byte(8'h03, "tmo_b0");
        recv_byte(8'h00, "tmo_b1");
        recv_byte(8'h00, "tmo_b2");
    endtask

    task automatic test_overrun();
        send_frame(16'h0102, 16'h0304);
        tick();
        send_byte(8'hAA);
        n_checks++;
        if (overrun_o !== 1'b1) begin
            n_fails++;
            $display("FAIL ovr_pulse: overrun_o=%b expected 1", overrun_o);
        end
        tick();
        n_checks++;
        if (overrun_o !== 1'b0) begin
            n_fails++;
            $display("FAIL ovr_width: overrun_o=%b expected 0", overrun_o);
        end
        n_checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h06) begin
            n_fails++;
            $display("FAIL ovr_tx: valid=%b data=%02h expected 1 06", tx_valid_o, tx_data_o);
        end
        recv_byte(8'h06, "ovr_b0");
        recv_byte(8'h04, "ovr_b1");
        recv_byte(8'h00, "ovr_b2");
    endtask

    task automatic test_reset_mid_tx();
        send_frame(16'h1234, 16'h4321);
        tick();
        recv_byte(8'h55, "rst_b0");
        rst_i = 1'b1;
        tick();
        n_checks++;
        if ({tx_valid_o, tx_data_o, busy_o, overrun_o, timeout_o} !== 12'd0) begin
            n_fails++;
            $display("FAIL rst_tx_outs: valid=%b data=%02h busy=%b ovr=%b tmo=%b expected all 0",
                     tx_valid_o, tx_data_o, busy_o, overrun_o, timeout_o);
        end
        n_checks++;
        if (add_a_o !== 16'd0 || add_b_o !== 16'd0) begin
            n_fails++;
            $display("FAIL rst_tx_ops: a=%04h b=%04h expected 0000 0000", add_a_o, add_b_o);
        end
        rst_i = 1'b0;
        tick();
        send_frame(16'h0001, 16'h0002);
        recv_byte(8'h03, "rst_new_b0");
        recv_byte(8'h00, "rst_new_b1");
        recv_byte(8'h00, "rst_new_b2");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_timeout();
        test_overrun();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
